// File: rtl/pipe_stall_ctrl_if.sv
// Hazard/stall bundle between the MIPS datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if;
    logic       div_reqE;
    logic       div_readyE;
    logic       MemtoRegE;
    logic       RegWriteE;
    logic [4:0] writeregE;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       dmem_wait;
    logic       exc_flush;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       flushM;
    logic       div_start;
    logic       div_cancel;
    logic       div_timeout;

    modport master (
        output div_reqE, div_readyE, MemtoRegE, RegWriteE, writeregE, rsD, rtD,
               dmem_wait, exc_flush,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushM,
               div_start, div_cancel, div_timeout
    );

    modport slave (
        input  div_reqE, div_readyE, MemtoRegE, RegWriteE, writeregE, rsD, rtD,
               dmem_wait, exc_flush,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushM,
               div_start, div_cancel, div_timeout
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipe: divider BUSY/DONE sequencing with watchdog,
// load-use interlock, data-memory freeze and exception flush.
module pipe_stall_ctrl #(
    parameter int DIV_MAX_CYC = 40,
    parameter int CNT_W       = 6
) (
    input  logic               clk,
    input  logic               reset,
    pipe_stall_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_MAX_CYC - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_div_timeout;
    logic             w_timeout_next;

    logic             w_lu;
    logic             w_div_stall;
    logic             w_div_bubble;
    logic             w_div_start;
    logic             w_div_cancel;

    assign w_lu = bus.MemtoRegE && bus.RegWriteE && (bus.writeregE != 5'd0) &&
                  ((bus.writeregE == bus.rsD) || (bus.writeregE == bus.rtD));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_div_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_div_timeout <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = 1'b0;
        w_div_stall    = 1'b0;
        w_div_bubble   = 1'b0;
        w_div_start    = 1'b0;
        w_div_cancel   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.div_reqE) begin
                    w_div_start  = 1'b1;
                    w_state_next = S_BUSY;
                    w_cnt_next   = '0;
                end
            end
            S_BUSY: begin
                w_div_stall  = 1'b1;
                w_div_bubble = 1'b1;
                if (r_cnt != CNT_LAST) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (bus.div_readyE) begin
                    w_state_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = S_IDLE;
                    w_timeout_next = 1'b1;
                    w_div_cancel   = 1'b1;
                    w_cnt_next     = '0;
                end
            end
            S_DONE: begin
                // The div only leaves EX once memory stops freezing the pipe.
                if (!bus.dmem_wait) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        if (bus.exc_flush) begin
            w_state_next   = S_IDLE;
            w_cnt_next     = '0;
            w_timeout_next = 1'b0;
            w_div_start    = 1'b0;
            w_div_cancel   = (r_state == S_BUSY);
        end
    end

    always_comb begin
        bus.stallF = w_div_stall | w_lu;
        bus.stallD = w_div_stall | w_lu;
        bus.stallE = w_div_stall;
        bus.stallM = 1'b0;
        bus.flushD = 1'b0;
        // ID/EX is already held by the divider, so a load-use bubble there would lose the instruction.
        bus.flushE = w_lu & ~w_div_stall;
        bus.flushM = w_div_bubble;

        if (bus.exc_flush) begin
            bus.stallF = 1'b0;
            bus.stallD = 1'b0;
            bus.stallE = 1'b0;
            bus.stallM = 1'b0;
            bus.flushD = 1'b1;
            bus.flushE = 1'b1;
            bus.flushM = 1'b1;
        end else if (bus.dmem_wait) begin
            bus.stallF = 1'b1;
            bus.stallD = 1'b1;
            bus.stallE = 1'b1;
            bus.stallM = 1'b1;
            bus.flushD = 1'b0;
            bus.flushE = 1'b0;
            bus.flushM = 1'b0;
        end
    end

    assign bus.div_start   = w_div_start;
    assign bus.div_cancel  = w_div_cancel;
    assign bus.div_timeout = r_div_timeout;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; output vector order is
// {stallF,stallD,stallE,stallM,flushD,flushE,flushM,div_start,div_cancel,div_timeout}.
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stall_ctrl_if bus();

    pipe_stall_ctrl #(
        .DIV_MAX_CYC (40),
        .CNT_W       (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [9:0] V_IDLE  = 10'b0000000000;
    localparam logic [9:0] V_START = 10'b0000000100;
    localparam logic [9:0] V_BUSY  = 10'b1110001000;
    localparam logic [9:0] V_LU    = 10'b1100010000;
    localparam logic [9:0] V_FRZ   = 10'b1111000000;
    localparam logic [9:0] V_TOCAN = 10'b1110001010;
    localparam logic [9:0] V_TOPLS = 10'b0000000001;
    localparam logic [9:0] V_EXCB  = 10'b0000111010;
    localparam logic [9:0] V_EXC   = 10'b0000111000;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [9:0] outs();
        return {bus.stallF, bus.stallD, bus.stallE, bus.stallM, bus.flushD, bus.flushE,
                bus.flushM, bus.div_start, bus.div_cancel, bus.div_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] e);
        @(negedge clk);
        check(tag, 32'(outs()), 32'(e));
    endtask

    task automatic expect_state(input string tag, input int e);
        check(tag, 32'(dut.r_state), 32'(e));
    endtask

    task automatic clear_inputs();
        bus.div_reqE   = 1'b0;
        bus.div_readyE = 1'b0;
        bus.MemtoRegE  = 1'b0;
        bus.RegWriteE  = 1'b0;
        bus.writeregE  = 5'd0;
        bus.rsD        = 5'd0;
        bus.rtD        = 5'd0;
        bus.dmem_wait  = 1'b0;
        bus.exc_flush  = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        expect_out("reset_outs", V_IDLE);
        expect_state("reset_state", 0);
        tick();
        reset = 1'b1;

        // Idle with everything low
        for (int i = 0; i < 5; i++) begin
            expect_out("t1_idle", V_IDLE);
            expect_state("t1_state", 0);
            tick();
        end

        // Divide completing 33 cycles after start
        bus.div_reqE = 1'b1;
        expect_out("t2_start", V_START);
        tick();
        for (int k = 1; k <= 33; k++) begin
            if (k == 33) bus.div_readyE = 1'b1;
            expect_out("t2_busy", V_BUSY);
            tick();
        end
        bus.div_readyE = 1'b0;
        expect_out("t2_done_no_relaunch", V_IDLE);
        expect_state("t2_done_state", 2);
        tick();
        bus.div_reqE = 1'b0;
        expect_out("t2_idle", V_IDLE);
        expect_state("t2_idle_state", 0);
        tick();

        // Load-use interlock
        bus.MemtoRegE = 1'b1;
        bus.RegWriteE = 1'b1;
        bus.writeregE = 5'd8;
        bus.rsD       = 5'd8;
        expect_out("t3_lu_rs", V_LU);
        tick();
        bus.rsD = 5'd0;
        bus.rtD = 5'd8;
        expect_out("t3_lu_rt", V_LU);
        tick();
        bus.writeregE = 5'd0;
        bus.rtD       = 5'd0;
        expect_out("t3_r0_no_stall", V_IDLE);
        tick();
        bus.writeregE = 5'd9;
        bus.rsD       = 5'd8;
        bus.rtD       = 5'd10;
        expect_out("t3_no_match", V_IDLE);
        tick();
        bus.writeregE = 5'd8;
        bus.RegWriteE = 1'b0;
        expect_out("t3_no_regwrite", V_IDLE);
        tick();
        clear_inputs();

        // Watchdog expiry
        bus.div_reqE = 1'b1;
        expect_out("t4_start", V_START);
        tick();
        for (int k = 1; k <= 39; k++) begin
            expect_out("t4_busy", V_BUSY);
            tick();
        end
        expect_out("t4_cancel", V_TOCAN);
        tick();
        bus.div_reqE = 1'b0;
        expect_out("t4_timeout", V_TOPLS);
        expect_state("t4_idle_state", 0);
        tick();
        expect_out("t4_timeout_once", V_IDLE);
        tick();

        // Exception flush during BUSY while memory also waits
        bus.div_reqE = 1'b1;
        expect_out("t5_start", V_START);
        tick();
        for (int k = 1; k <= 9; k++) begin
            expect_out("t5_busy", V_BUSY);
            tick();
        end
        bus.exc_flush = 1'b1;
        bus.dmem_wait = 1'b1;
        expect_out("t5_exc_busy", V_EXCB);
        tick();
        clear_inputs();
        expect_out("t5_after", V_IDLE);
        expect_state("t5_idle_state", 0);
        tick();
        bus.div_reqE  = 1'b1;
        bus.exc_flush = 1'b1;
        expect_out("t5_exc_idle_no_start", V_EXC);
        tick();
        clear_inputs();
        expect_out("t5_exc_idle_after", V_IDLE);
        expect_state("t5_exc_idle_state", 0);
        tick();

        // Divider result arriving under a memory freeze
        bus.div_reqE = 1'b1;
        expect_out("t6_start", V_START);
        tick();
        for (int k = 1; k <= 4; k++) begin
            expect_out("t6_busy", V_BUSY);
            tick();
        end
        bus.div_readyE = 1'b1;
        bus.dmem_wait  = 1'b1;
        expect_out("t6_ready_frozen", V_FRZ);
        tick();
        bus.div_readyE = 1'b0;
        expect_out("t6_done_frz1", V_FRZ);
        expect_state("t6_done_st1", 2);
        tick();
        expect_out("t6_done_frz2", V_FRZ);
        expect_state("t6_done_st2", 2);
        tick();
        bus.dmem_wait = 1'b0;
        expect_out("t6_done_release", V_IDLE);
        expect_state("t6_done_st3", 2);
        tick();
        bus.div_reqE = 1'b0;
        expect_out("t6_idle", V_IDLE);
        expect_state("t6_idle_state", 0);
        tick();

        // Freeze priority over load-use
        bus.dmem_wait = 1'b1;
        expect_out("t7_wait_idle", V_FRZ);
        tick();
        bus.MemtoRegE = 1'b1;
        bus.RegWriteE = 1'b1;
        bus.writeregE = 5'd3;
        bus.rtD       = 5'd3;
        expect_out("t7_wait_over_lu", V_FRZ);
        tick();
        clear_inputs();

        // Reset mid-BUSY: straight back to IDLE without a cancel
        bus.div_reqE = 1'b1;
        expect_out("t8_start", V_START);
        tick();
        for (int k = 1; k <= 3; k++) begin
            expect_out("t8_busy", V_BUSY);
            tick();
        end
        bus.div_reqE = 1'b0;
        #1;
        reset = 1'b0;
        expect_out("t8_reset_outs", V_IDLE);
        expect_state("t8_reset_state", 0);
        tick();
        reset = 1'b1;
        expect_out("t8_after_reset", V_IDLE);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
